chunked_seq_adder: RTL and testbench

Parametrised multi-cycle signed adder/subtractor. It processes a WIDTH-bit operand pair CHUNK bits per clock, rippling the carry through a register between cycles, and reports sum, carry and signed overflow with a start/busy/done handshake. It is the sequential successor to the single-cycle 32-bit adder. It trades latency for a short carry chain, and it adds a subtract mode. It sits in the arithmetic library beside the combinational adders and feeds the multi-cycle multiplier/divider datapaths.

---
 rtl/arith_pkg.sv | 31 +++
 rtl/chunked_seq_adder_if.sv | 32 +++
 rtl/chunked_seq_adder_chunk_add.sv | 26 ++
 rtl/chunked_seq_adder.sv | 143 ++++++++++++++
 tb/tb_chunked_seq_adder.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/arith_pkg.sv
// ============================================================================
// Module      : arith_pkg
// Description : Shared sequencer state encoding and width helper for the
//               multi-cycle arithmetic library.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package arith_pkg;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } seq_state_t;

   // Ceiling log2, never less than 1 so that counters always have a bit.
   function automatic int clog2_min1(input int n);
      int r;
      int v;
      r = 0;
      v = 1;
      while (v < n) begin
         v = v * 2;
         r = r + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/chunked_seq_adder_if.sv
// ============================================================================
// Module      : chunked_seq_adder_if
// Description : Request/result bundle for the chunked sequential adder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface chunked_seq_adder_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             sub;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             carry;
   logic             overflow;

   modport master (
      output start, sub, x, y,
      input  busy, done, sum, carry, overflow
   );

   modport slave (
      input  start, sub, x, y,
      output busy, done, sum, carry, overflow
   );
endinterface

`default_nettype wire

// File: rtl/chunked_seq_adder_chunk_add.sv
// ============================================================================
// Module      : chunk_add
// Description : Combinational CHUNK-bit adder with carry in and carry out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module chunk_add #(
   parameter int CHUNK = 8
) (
   input  wire logic [CHUNK-1:0] i_a,
   input  wire logic [CHUNK-1:0] i_b,
   input  wire logic             i_cin,
   output logic      [CHUNK-1:0] o_sum,
   output logic                  o_cout
);

   logic [CHUNK:0] w_total;

   assign w_total = {1'b0, i_a} + {1'b0, i_b} + {{CHUNK{1'b0}}, i_cin};
   assign o_sum   = w_total[CHUNK-1:0];
   assign o_cout  = w_total[CHUNK];

endmodule

`default_nettype wire

// File: rtl/chunked_seq_adder.sv
// ============================================================================
// Module      : chunked_seq_adder
// Description : Multi-cycle signed add/subtract, CHUNK bits per clock with a
//               registered carry between chunks; start/busy/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module chunked_seq_adder
   import arith_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  wire logic          clk,
   input  wire logic          rst,
   chunked_seq_adder_if.slave bus
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDX_W  = clog2_min1(NCHUNK);
   localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NCHUNK - 1);
   localparam int MSB    = WIDTH - 1;

   seq_state_t       r_state;
   seq_state_t       w_state_nxt;
   logic             w_load;
   logic             w_step;
   logic             w_finish;

   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_acc;
   logic             r_c;
   logic [IDX_W-1:0] r_idx;
   logic [WIDTH-1:0] r_sum;
   logic             r_carry;
   logic             r_ovf;
   logic             r_done;

   int               w_base;
   logic [CHUNK-1:0] w_a_chunk;
   logic [CHUNK-1:0] w_b_chunk;
   logic [CHUNK-1:0] w_chunk_sum;
   logic             w_chunk_cout;
   logic [WIDTH-1:0] w_acc_nxt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_step      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.start) begin
               w_load      = 1'b1;
               w_state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            w_step = 1'b1;
            if (r_idx == C_LAST_IDX) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign w_finish = w_step && (r_idx == C_LAST_IDX);

   // One shared chunk adder; the index selects which slice it sees this cycle.
   always_comb begin
      w_base    = int'(r_idx) * CHUNK;
      w_a_chunk = r_a[w_base +: CHUNK];
      w_b_chunk = r_b[w_base +: CHUNK];
   end

   chunk_add #(
      .CHUNK (CHUNK)
   ) u_chunk_add (
      .i_a    (w_a_chunk),
      .i_b    (w_b_chunk),
      .i_cin  (r_c),
      .o_sum  (w_chunk_sum),
      .o_cout (w_chunk_cout)
   );

   always_comb begin
      w_acc_nxt                   = r_acc;
      w_acc_nxt[w_base +: CHUNK]  = w_chunk_sum;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a     <= '0;
         r_b     <= '0;
         r_acc   <= '0;
         r_c     <= 1'b0;
         r_idx   <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_ovf   <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= w_finish;
         if (w_load) begin
            // Subtract is x + ~y + 1, the +1 entering as the initial carry.
            r_a   <= bus.x;
            r_b   <= bus.sub ? ~bus.y : bus.y;
            r_c   <= bus.sub;
            r_idx <= '0;
         end else if (w_step) begin
            r_acc <= w_acc_nxt;
            r_c   <= w_chunk_cout;
            if (w_finish) begin
               r_idx   <= '0;
               r_sum   <= w_acc_nxt;
               r_carry <= w_chunk_cout;
               r_ovf   <= (r_a[MSB] == r_b[MSB]) && (w_acc_nxt[MSB] != r_a[MSB]);
            end else begin
               r_idx <= r_idx + IDX_W'(1);
            end
         end
      end
   end

   assign bus.busy     = (r_state == ST_RUN);
   assign bus.done     = r_done;
   assign bus.sum      = r_sum;
   assign bus.carry    = r_carry;
   assign bus.overflow = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_chunked_seq_adder.sv
// ============================================================================
// Module      : tb_chunked_seq_adder
// Description : Self-checking bench for chunked_seq_adder (32/8 and 16/16).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_chunked_seq_adder;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_bad;
   int   ncyc;
   logic sel;

   chunked_seq_adder_if #(.WIDTH(32)) bus32 ();
   chunked_seq_adder_if #(.WIDTH(16)) bus16 ();

   chunked_seq_adder #(.WIDTH(32), .CHUNK(8)) u_dut32 (
      .clk (clk),
      .rst (rst),
      .bus (bus32.slave)
   );

   chunked_seq_adder #(.WIDTH(16), .CHUNK(16)) u_dut16 (
      .clk (clk),
      .rst (rst),
      .bus (bus16.slave)
   );

   logic        obs_busy;
   logic        obs_done;
   logic [31:0] obs_sum;
   logic        obs_carry;
   logic        obs_ovf;

   assign obs_busy  = sel ? bus16.busy     : bus32.busy;
   assign obs_done  = sel ? bus16.done     : bus32.done;
   assign obs_sum   = sel ? {16'h0, bus16.sum} : bus32.sum;
   assign obs_carry = sel ? bus16.carry    : bus32.carry;
   assign obs_ovf   = sel ? bus16.overflow : bus32.overflow;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial ncyc = 0;
   always @(posedge clk) ncyc <= ncyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: observed=still running required=finished");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the mathematical operand values.
   function automatic void model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic s, output logic [31:0] es,
                                 output logic ec, output logic eo);
      longint m, ua, ub, full, sa, sb, r;
      m    = (longint'(1) << w) - 1;
      ua   = longint'({32'd0, a}) & m;
      ub   = longint'({32'd0, b}) & m;
      full = s ? (ua + ((~ub) & m) + 1) : (ua + ub);
      es   = 32'(full & m);
      ec   = ((full >> w) & 1) != 0;
      sa   = (((ua >> (w - 1)) & 1) != 0) ? ua - (m + 1) : ua;
      sb   = (((ub >> (w - 1)) & 1) != 0) ? ub - (m + 1) : ub;
      r    = s ? (sa - sb) : (sa + sb);
      eo   = (r > (m >> 1)) || (r < -((m >> 1) + 1));
   endfunction

   task automatic drive(input int d, input logic st, input logic s,
                        input logic [31:0] a, input logic [31:0] b);
      if (d == 0) begin
         bus32.start = st; bus32.sub = s; bus32.x = a; bus32.y = b;
      end else begin
         bus16.start = st; bus16.sub = s; bus16.x = a[15:0]; bus16.y = b[15:0];
      end
   endtask

   // Entered and left on a falling edge; inj>0 pulses a spurious start mid-run.
   task automatic do_op(input int d, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input int inj, output int done_at);
      int          nch;
      int          lat;
      logic [31:0] es;
      logic        ec, eo;
      nch = (d == 0) ? 4 : 1;
      lat = 0;
      sel = (d != 0);
      model((d == 0) ? 32 : 16, a, b, s, es, ec, eo);
      drive(d, 1'b1, s, a, b);
      @(posedge clk);
      @(negedge clk);
      chk("busy_after_start", obs_busy, 1);
      drive(d, 1'b0, ~s, $urandom, $urandom);
      while (obs_done !== 1'b1 && lat < 10) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (inj != 0 && lat == inj) drive(d, 1'b1, ~s, $urandom, $urandom);
         else                        drive(d, 1'b0, ~s, $urandom, $urandom);
      end
      chk("latency", lat, nch);
      chk("sum", obs_sum, es);
      chk("carry", obs_carry, ec);
      chk("overflow", obs_ovf, eo);
      chk("busy_low_at_done", obs_busy, 0);
      done_at = ncyc;
   endtask

   task automatic idle_check(input logic [31:0] held_sum);
      @(negedge clk);
      chk("done_pulse_one_cycle", obs_done, 0);
      chk("idle_busy", obs_busy, 0);
      chk("sum_held", obs_sum, held_sum);
   endtask

   initial begin
      int          t0, t1;
      logic [31:0] ra, rb;
      logic        seen_done;
      n_cmp = 0;
      n_bad = 0;
      sel   = 1'b0;
      rst   = 1'b1;
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      chk("reset_busy", obs_busy, 0);
      chk("reset_done", obs_done, 0);
      chk("reset_sum", obs_sum, 0);
      chk("reset_carry", obs_carry, 0);
      chk("reset_ovf", obs_ovf, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      do_op(0, 32'd5, 32'd7, 1'b0, 0, t0);
      idle_check(32'd12);
      do_op(0, 32'h7FFF_FFFF, 32'h1, 1'b0, 0, t0);
      do_op(0, 32'hFFFF_FFFF, 32'h1, 1'b0, 0, t0);
      do_op(0, 32'h0, 32'h1, 1'b1, 0, t0);
      do_op(0, 32'h8000_0000, 32'h1, 1'b1, 0, t0);

      // Spurious start two cycles into the run must be dropped.
      do_op(0, 32'h1234_5678, 32'h1111_1111, 1'b0, 2, t0);
      idle_check(32'h2345_6789);

      // Start in the done cycle: next done exactly NCHUNK+1 cycles later.
      do_op(0, 32'd100, 32'd23, 1'b1, 0, t0);
      do_op(0, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0, 0, t1);
      chk("back_to_back_spacing", t1 - t0, 5);

      // Asynchronous reset mid-run.
      sel = 1'b0;
      drive(0, 1'b1, 1'b0, 32'h5555_5555, 32'h3333_3333);
      @(posedge clk);
      @(negedge clk);
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      @(posedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_busy", obs_busy, 0);
      chk("arst_done", obs_done, 0);
      chk("arst_sum", obs_sum, 0);
      chk("arst_carry", obs_carry, 0);
      chk("arst_ovf", obs_ovf, 0);
      @(negedge clk);
      rst = 1'b0;
      seen_done = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (obs_done === 1'b1) seen_done = 1'b1;
      end
      chk("arst_no_done", seen_done, 0);
      do_op(0, 32'hFFFF_FFFD, 32'hFFFF_FFFC, 1'b0, 0, t0);

      // Randomized operations, alternating idle gaps and back-to-back issue.
      for (int k = 0; k < 24; k++) begin
         ra = $urandom;
         rb = $urandom;
         if (k % 6 == 0) ra = {ra[31], {31{~ra[31]}}};
         do_op(0, ra, rb, 1'($urandom_range(0, 1)), 0, t0);
         if (k % 2 == 0) @(negedge clk);
      end

      // Single-chunk configuration.
      do_op(1, 32'h7FFF, 32'h0001, 1'b0, 0, t0);
      for (int k = 0; k < 8; k++) begin
         do_op(1, $urandom, $urandom, 1'($urandom_range(0, 1)), 0, t0);
      end
      do_op(1, 32'h8000, 32'h0001, 1'b1, 0, t0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
